vend_arbiter: RTL
=================

VEND_ARBITER -- requirements
Module: vend_arbiter

Interface
REQ-001 Parameter PRICE, default 4, credits deducted per vend.
REQ-002 Parameter DISPENSE_CYCLES, default 3, cycles drop is held per vend (legal 1..7).
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 coin_a  input  2  port A coin: 00 none, 01 = 1 credit, 10 = 2 credits, 11 = 3 credits.
REQ-006 coin_b  input  2  port B coin, same encoding.
REQ-007 credit_a  output  4  port A credit balance, 0..15.
REQ-008 credit_b  output  4  port B credit balance, 0..15.
REQ-009 drop  output  2  one-hot dispense strobe: bit 0 = port A, bit 1 = port B.
REQ-010 busy  output  1  shared dispenser occupied (state DISPENSE).

Function
REQ-011 The block SHALL share one dispenser between two customer ports, each with its own credit register.
REQ-012 A nonzero coin at edge n SHALL add its value to that port's credit, visible after edge n (1-cycle latency).
REQ-013 Credit arithmetic SHALL be 5-bit internally, saturating at 15; excess value is discarded.
REQ-014 Coins SHALL be accepted every cycle, including during DISPENSE.
REQ-015 Port x requests when credit_x >= PRICE (combinational, from registered credit).
REQ-016 FSM states: IDLE, DISPENSE.
REQ-017 IDLE: no request -> stay IDLE; one request -> grant it; both -> grant the port not served last (round-robin).
REQ-018 On grant, next state DISPENSE, dispense counter loaded with DISPENSE_CYCLES-1, last-served pointer updated to the granted port.
REQ-019 On the grant edge, granted credit SHALL become sat15(credit + coin - PRICE); coin in that cycle is not lost.
REQ-020 DISPENSE: drop[granted] = 1, other bit 0, busy = 1; counter decrements each cycle; at counter 0 next state IDLE.
REQ-021 Exactly one IDLE cycle SHALL separate consecutive vends; drop and busy are 0 in IDLE.
REQ-022 A port still at credit >= PRICE after its vend SHALL be re-served (subject to round-robin) from the next IDLE cycle.
REQ-023 Requests arising during DISPENSE SHALL wait; they are never dropped.
REQ-024 Outputs credit_a, credit_b, drop, busy SHALL be driven from registers or state only (no coin-to-output combinational path).

Reset
REQ-025 reset = 0 SHALL immediately force state IDLE, credits 0, drop 00, busy 0, counter 0, last-served = B (A wins first tie).
REQ-026 Reset asserted mid-DISPENSE SHALL abort the vend with no drop pulse after release; deducted credit is not refunded.
REQ-027 Coins present while reset = 0 SHALL be ignored.

Structure
REQ-028 Package vend_pkg SHALL hold the state enum, coin encoding enum, and PRICE / DISPENSE_CYCLES defaults.
REQ-029 Sub-module credit_accum (coin in, deduct strobe in, 4-bit saturating credit out), instantiated once per port.
REQ-030 Arbitration, FSM, counter, and last-served pointer SHALL live in vend_arbiter.

Verification
REQ-031 Reset; coin_a = 10 two consecutive cycles -> credit_a 2 then 4; next edge drop = 01, busy = 1 for 3 cycles, credit_a = 0.
REQ-032 Both ports at credit 4 in same IDLE cycle after reset -> A served first (drop = 01 x3), one IDLE cycle, then B (drop = 10 x3).
REQ-033 credit_a = 14, coin_a = 11 -> credit_a = 15 (saturation); continued coins hold 15.
REQ-034 credit_b = 4, coin_b = 11 on grant edge -> credit_b = 3 entering DISPENSE; no re-grant to B.
REQ-035 credit_a = 8, B idle -> two A vends separated by one IDLE cycle, credit_a ends 0; coins during DISPENSE accumulate.
REQ-036 reset to 0 on 2nd DISPENSE cycle -> drop/busy clear immediately, credits 0, IDLE after release, no further drop.

Source files
------------

// File: rtl/vend_pkg.sv
// Purpose : shared types and defaults for the two-port vending arbiter.
// Latency : n/a (types, constants and a saturation helper only).
// Backpr. : n/a.
package vend_pkg;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_DISPENSE = 1'b1
   } state_e;

   // The coin code is numerically equal to its credit value.
   typedef enum logic [1:0] {
      COIN_NONE = 2'b00,
      COIN_1    = 2'b01,
      COIN_2    = 2'b10,
      COIN_3    = 2'b11
   } coin_e;

   localparam int PRICE_DEF           = 4;
   localparam int DISPENSE_CYCLES_DEF = 3;
   localparam int CNT_W               = 3;

   // Clamp a 5-bit intermediate credit to the 4-bit range 0..15.
   function automatic logic [3:0] sat15(input logic [4:0] v);
      return v[4] ? 4'hF : v[3:0];
   endfunction

endpackage

// File: rtl/vend_arbiter_if.sv
// Purpose : coin inputs and credit/dispense outputs of the vending arbiter.
// Ports   : coin_a/coin_b (2b codes) in; credit_a/credit_b (4b), drop (2b one-hot), busy out.
// Backpr. : none; coins are accepted every cycle.
interface vend_arbiter_if;
   logic [1:0] coin_a;
   logic [1:0] coin_b;
   logic [3:0] credit_a;
   logic [3:0] credit_b;
   logic [1:0] drop;
   logic       busy;

   // Customer/coin-mech side.
   modport master (
      output coin_a, coin_b,
      input  credit_a, credit_b, drop, busy
   );

   // Arbiter side.
   modport slave (
      input  coin_a, coin_b,
      output credit_a, credit_b, drop, busy
   );
endinterface

// File: rtl/credit_accum.sv
// Purpose : per-port saturating credit register (coin add, vend-price deduct).
// Latency : 1 cycle coin -> credit_o; credit_o is a register output.
// Backpr. : none; a coin is added every cycle it is nonzero, also on a deduct edge.
module credit_accum
   import vend_pkg::*;
#(
   parameter int PRICE = PRICE_DEF
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] coin_i,
   input  logic       deduct_i,
   output logic [3:0] credit_o
);

   logic [3:0] credit_q;
   logic [3:0] credit_d;
   logic [4:0] sum;

   // Deduct is only raised when credit_q >= PRICE, so the 5-bit difference
   // never wraps; only the upper end needs clamping.
   always_comb begin
      sum = {1'b0, credit_q} + {3'b000, coin_i};
      if (deduct_i) begin
         sum = sum - 5'(PRICE);
      end
      credit_d = sat15(sum);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         credit_q <= 4'd0;
      end else begin
         credit_q <= credit_d;
      end
   end

   assign credit_o = credit_q;

endmodule

// File: rtl/vend_arbiter.sv
// Purpose : two customer ports sharing one dispenser, round-robin on ties.
// Ports   : clk_i, rst_ni (async active-low), bus (slave modport: coins in, credits/drop/busy out).
// Latency : grant on the first edge a port sits at credit >= PRICE in IDLE; drop held DISPENSE_CYCLES.
module vend_arbiter
   import vend_pkg::*;
#(
   parameter int PRICE           = PRICE_DEF,
   parameter int DISPENSE_CYCLES = DISPENSE_CYCLES_DEF
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   vend_arbiter_if.slave  bus
);

   localparam logic [4:0]       PRICE5   = 5'(PRICE);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DISPENSE_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last_q, last_d;   // 0 = port A, 1 = port B; also the port being served
   logic             req_a, req_b;
   logic             grant_port;
   logic             deduct_a, deduct_b;

   credit_accum #(.PRICE(PRICE)) u_acc_a (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .coin_i   (bus.coin_a),
      .deduct_i (deduct_a),
      .credit_o (bus.credit_a)
   );

   credit_accum #(.PRICE(PRICE)) u_acc_b (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .coin_i   (bus.coin_b),
      .deduct_i (deduct_b),
      .credit_o (bus.credit_b)
   );

   // Requests come from registered credit only, so coins never reach outputs combinationally.
   assign req_a = ({1'b0, bus.credit_a} >= PRICE5);
   assign req_b = ({1'b0, bus.credit_b} >= PRICE5);

   always_comb begin
      if (req_a && req_b) begin
         grant_port = ~last_q;
      end else if (req_b) begin
         grant_port = 1'b1;
      end else begin
         grant_port = 1'b0;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      deduct_a = 1'b0;
      deduct_b = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_a || req_b) begin
               state_d  = ST_DISPENSE;
               cnt_d    = CNT_LOAD;
               last_d   = grant_port;
               deduct_a = ~grant_port;
               deduct_b = grant_port;
            end
         end
         ST_DISPENSE: begin
            // Always returning through IDLE gives the one-cycle gap between vends.
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         last_q  <= 1'b1;   // B counts as last served, so A wins the first tie
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   assign bus.busy = (state_q == ST_DISPENSE);
   assign bus.drop = (state_q == ST_DISPENSE) ? (last_q ? 2'b10 : 2'b01) : 2'b00;

endmodule
